ternary_weight_loader: RTL and testbench

//  Upstream stage of the ternary matrix-vector multiplier. Streams 16-bit words from the
//  pad bus into the packed 2-bit ternary weight register (MAX_OUT_LEN x MAX_IN_LEN) read by the mult core.

---
 rtl/ternary_pkg.sv | 22 ++
 rtl/ternary_word_sanitize.sv | 22 ++
 rtl/ternary_weight_loader.sv | 126 ++++++++++++
 tb/tb_ternary_weight_loader.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ternary_pkg.sv
// Shared definitions for the ternary weight loader: trit codes, FSM encoding and
// the helpers that size the word counter from the matrix geometry.
package ternary_pkg;

  localparam logic [1:0] TRIT_ZERO    = 2'b00;
  localparam logic [1:0] TRIT_POS     = 2'b01;
  localparam logic [1:0] TRIT_NEG     = 2'b11;
  localparam logic [1:0] TRIT_ILLEGAL = 2'b10;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_FILL = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  function automatic int calc_nwords(input int in_len, input int out_len, input int word_w);
    return (2 * in_len * out_len) / word_w;
  endfunction

  function automatic int calc_cnt_w(input int nwords);
    return (nwords <= 1) ? 1 : $clog2(nwords);
  endfunction

endpackage

// File: rtl/ternary_word_sanitize.sv
// Combinational cleaner for one bus word: illegal 2'b10 codes become zero and
// are reported through a single flag.
module ternary_word_sanitize
  import ternary_pkg::*;
#(
  parameter int WORD_W = 16
) (
  input  logic [WORD_W-1:0] word_i,
  output logic [WORD_W-1:0] word_o,
  output logic              illegal_o
);

  logic [WORD_W/2-1:0] code_ill;

  for (genvar gi = 0; gi < WORD_W / 2; gi++) begin : g_code
    assign code_ill[gi]          = (word_i[2*gi +: 2] == TRIT_ILLEGAL);
    assign word_o[2*gi +: 2]     = code_ill[gi] ? TRIT_ZERO : word_i[2*gi +: 2];
  end

  assign illegal_o = |code_ill;

endmodule

// File: rtl/ternary_weight_loader.sv
// Streams bus words into the packed ternary weight register for the mult core,
// tracking load progress and flagging complete, uninterrupted loads.
module ternary_weight_loader
  import ternary_pkg::*;
#(
  parameter int MAX_IN_LEN  = 16,
  parameter int MAX_OUT_LEN = 8,
  parameter int WORD_W      = 16,
  localparam int NWORDS     = calc_nwords(MAX_IN_LEN, MAX_OUT_LEN, WORD_W),
  localparam int CNT_W      = calc_cnt_w(NWORDS)
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 ena,
  input  logic [WORD_W-1:0]                    ui_input,
  input  logic                                 ui_valid,
  output logic [2*MAX_IN_LEN*MAX_OUT_LEN-1:0]  uo_weights,
  output logic                                 uo_done,
  output logic                                 uo_wvalid,
  output logic                                 uo_err,
  output logic [CNT_W-1:0]                     uo_word_cnt
);

  if ((2 * MAX_IN_LEN * MAX_OUT_LEN) % WORD_W != 0) begin : g_bad_geometry
    $error("weight array size must be a multiple of WORD_W");
  end

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NWORDS - 1);

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              wvalid_q, wvalid_d;
  logic              err_q, err_d;
  logic [WORD_W-1:0] weights_q [NWORDS];

  logic [WORD_W-1:0] clean_word;
  logic              word_ill;
  logic              accept;

  ternary_word_sanitize #(.WORD_W(WORD_W)) u_sanitize (
    .word_i    (ui_input),
    .word_o    (clean_word),
    .illegal_o (word_ill)
  );

  // DONE ignores the bus so a word held across the completing edge is not re-taken.
  assign accept = ena & ui_valid & (state_q != ST_DONE);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    wvalid_d = wvalid_q;
    err_d    = err_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          wvalid_d = 1'b0;
          err_d    = word_ill;
          if (cnt_q == LAST_IDX) begin
            state_d  = ST_DONE;
            cnt_d    = '0;
            wvalid_d = 1'b1;
          end else begin
            state_d = ST_FILL;
            cnt_d   = cnt_q + CNT_W'(1);
          end
        end
      end
      ST_FILL: begin
        if (!ena) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (ui_valid) begin
          err_d = err_q | word_ill;
          if (cnt_q == LAST_IDX) begin
            state_d  = ST_DONE;
            cnt_d    = '0;
            wvalid_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      wvalid_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      wvalid_q <= wvalid_d;
      err_q    <= err_d;
    end
  end

  // The counter is always the write index; it is 0 in IDLE, so word 0 lands there too.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NWORDS; i++) weights_q[i] <= '0;
    end else if (accept) begin
      for (int i = 0; i < NWORDS; i++) begin
        if (cnt_q == CNT_W'(i)) weights_q[i] <= clean_word;
      end
    end
  end

  for (genvar gi = 0; gi < NWORDS; gi++) begin : g_out
    assign uo_weights[gi*WORD_W +: WORD_W] = weights_q[gi];
  end

  assign uo_done     = (state_q == ST_DONE);
  assign uo_wvalid   = wvalid_q;
  assign uo_err      = err_q;
  assign uo_word_cnt = cnt_q;

endmodule

// File: tb/tb_ternary_weight_loader.sv
// Self-checking bench: randomized loads compared against a word-level model of the loader.
module tb_ternary_weight_loader;

  localparam int NW = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         ena = 1'b0;
  logic [15:0]  ui_input = '0;
  logic         ui_valid = 1'b0;
  logic [255:0] uo_weights;
  logic         uo_done, uo_wvalid, uo_err;
  logic [3:0]   uo_word_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: words stored so far, next index, load-in-progress flag.
  logic [15:0] m_words [NW];
  int          m_next;
  bit          m_loading, m_in_done, m_done, m_err, m_wvalid;

  ternary_weight_loader dut (
    .clk         (clk),
    .rst         (rst),
    .ena         (ena),
    .ui_input    (ui_input),
    .ui_valid    (ui_valid),
    .uo_weights  (uo_weights),
    .uo_done     (uo_done),
    .uo_wvalid   (uo_wvalid),
    .uo_err      (uo_err),
    .uo_word_cnt (uo_word_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] san(input logic [15:0] w);
    logic [15:0] r;
    for (int i = 0; i < 8; i++) r[2*i +: 2] = (w[2*i +: 2] == 2'b10) ? 2'b00 : w[2*i +: 2];
    return r;
  endfunction

  function automatic bit has_ill(input logic [15:0] w);
    return san(w) != w || (w != 16'h0 && 1'b0);
  endfunction

  function automatic logic [15:0] mk_legal(input logic [15:0] w);
    logic [15:0] r = w;
    for (int i = 0; i < 8; i++) if (r[2*i +: 2] == 2'b10) r[2*i +: 2] = 2'b01;
    return r;
  endfunction

  function automatic logic [255:0] m_flat();
    logic [255:0] r;
    for (int k = 0; k < NW; k++) r[16*k +: 16] = m_words[k];
    return r;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NW; k++) m_words[k] = '0;
    m_next = 0; m_loading = 0; m_in_done = 0; m_done = 0; m_err = 0; m_wvalid = 0;
  endtask

  task automatic model_step(input bit e, input bit v, input logic [15:0] w);
    m_done = 0;
    if (m_in_done) begin
      m_in_done = 0;
    end else if (e && v) begin
      if (!m_loading) begin
        m_loading = 1; m_next = 0; m_wvalid = 0; m_err = 0;
      end
      m_words[m_next] = san(w);
      m_err = m_err | has_ill(w);
      m_next++;
      if (m_next == NW) begin
        m_next = 0; m_loading = 0; m_done = 1; m_in_done = 1; m_wvalid = 1;
      end
    end else if (!e) begin
      m_loading = 0; m_next = 0;
    end
  endtask

  // Drive one cycle, advance the model, and return 1 time unit after the edge.
  task automatic cyc(input bit e, input bit v, input logic [15:0] w);
    ena = e; ui_valid = v; ui_input = w;
    @(posedge clk);
    #1;
    model_step(e, v, w);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    n_checks++; if (uo_weights !== '0) $display("FAIL reset_weights got %h want 0", uo_weights); else n_pass++;
    n_checks++; if (uo_done !== 1'b0) $display("FAIL reset_done got %b want 0", uo_done); else n_pass++;
    n_checks++; if (uo_wvalid !== 1'b0) $display("FAIL reset_wvalid got %b want 0", uo_wvalid); else n_pass++;
    n_checks++; if (uo_err !== 1'b0) $display("FAIL reset_err got %b want 0", uo_err); else n_pass++;
    n_checks++; if (uo_word_cnt !== 4'd0) $display("FAIL reset_cnt got %0d want 0", uo_word_cnt); else n_pass++;
    rst = 1'b0;
    $display("test_reset done");
  endtask

  task automatic test_full_load();
    int done_seen = 0;
    for (int k = 0; k < NW; k++) begin
      cyc(1'b1, 1'b1, 16'h5555 + 16'(k));
      if (uo_done) done_seen++;
      n_checks++;
      if (uo_word_cnt !== 4'(m_next)) $display("FAIL full_cnt k=%0d got %0d want %0d", k, uo_word_cnt, m_next);
      else n_pass++;
    end
    n_checks++; if (uo_done !== 1'b1 || done_seen != 1) $display("FAIL full_done got %b seen %0d want 1/1", uo_done, done_seen); else n_pass++;
    n_checks++; if (uo_wvalid !== 1'b1) $display("FAIL full_wvalid got %b want 1", uo_wvalid); else n_pass++;
    n_checks++; if (uo_err !== 1'b1) $display("FAIL full_err got %b want 1", uo_err); else n_pass++;
    for (int k = 0; k < NW; k++) begin
      n_checks++;
      if (uo_weights[16*k +: 16] !== san(16'h5555 + 16'(k)))
        $display("FAIL full_word k=%0d got %h want %h", k, uo_weights[16*k +: 16], san(16'h5555 + 16'(k)));
      else n_pass++;
    end
    cyc(1'b0, 1'b0, 16'h0);
    n_checks++; if (uo_done !== 1'b0) $display("FAIL full_done_pulse got %b want 0", uo_done); else n_pass++;
    $display("test_full_load done");
  endtask

  task automatic test_valid_gaps();
    int done_seen = 0;
    for (int i = 0; i < 32; i++) begin
      cyc(1'b1, (i % 2) == 0, 16'hFFFF);
      if (uo_done) done_seen++;
      n_checks++;
      if (uo_word_cnt !== 4'(m_next) || uo_done !== m_done)
        $display("FAIL gaps_step i=%0d cnt %0d done %b want cnt %0d done %b", i, uo_word_cnt, uo_done, m_next, m_done);
      else n_pass++;
    end
    n_checks++; if (done_seen != 1) $display("FAIL gaps_done_count got %0d want 1", done_seen); else n_pass++;
    n_checks++; if (uo_weights !== {256{1'b1}}) $display("FAIL gaps_weights got %h want all ones", uo_weights); else n_pass++;
    n_checks++; if (uo_err !== 1'b0 || uo_wvalid !== 1'b1) $display("FAIL gaps_flags err %b wvalid %b want 0 1", uo_err, uo_wvalid); else n_pass++;
    cyc(1'b0, 1'b0, 16'h0);
    $display("test_valid_gaps done");
  endtask

  task automatic test_abort();
    for (int k = 0; k < 5; k++) cyc(1'b1, 1'b1, 16'($urandom));
    cyc(1'b0, 1'b1, 16'h1111);
    n_checks++;
    if (uo_word_cnt !== 4'd0 || uo_wvalid !== 1'b0 || uo_done !== 1'b0)
      $display("FAIL abort_state cnt %0d wvalid %b done %b want 0 0 0", uo_word_cnt, uo_wvalid, uo_done);
    else n_pass++;
    n_checks++; if (uo_weights !== m_flat()) $display("FAIL abort_weights got %h want %h", uo_weights, m_flat()); else n_pass++;
    for (int k = 0; k < NW; k++) cyc(1'b1, 1'b1, 16'h0000);
    n_checks++;
    if (uo_weights !== '0 || uo_done !== 1'b1 || uo_wvalid !== 1'b1)
      $display("FAIL abort_reload weights %h done %b wvalid %b want 0 1 1", uo_weights, uo_done, uo_wvalid);
    else n_pass++;
    cyc(1'b0, 1'b0, 16'h0);
    $display("test_abort done");
  endtask

  task automatic test_illegal();
    for (int k = 0; k < NW; k++) cyc(1'b1, 1'b1, (k == 3) ? 16'h8001 : mk_legal(16'($urandom)));
    n_checks++; if (uo_weights[63:48] !== 16'h0001) $display("FAIL ill_word3 got %h want 0001", uo_weights[63:48]); else n_pass++;
    n_checks++; if (uo_err !== 1'b1) $display("FAIL ill_err got %b want 1", uo_err); else n_pass++;
    cyc(1'b0, 1'b0, 16'h0);
    cyc(1'b1, 1'b1, mk_legal(16'($urandom)));
    n_checks++; if (uo_err !== 1'b0) $display("FAIL ill_clear got %b want 0", uo_err); else n_pass++;
    n_checks++; if (uo_wvalid !== 1'b0) $display("FAIL ill_wvalid_drop got %b want 0", uo_wvalid); else n_pass++;
    for (int k = 1; k < NW; k++) cyc(1'b1, 1'b1, mk_legal(16'($urandom)));
    n_checks++; if (uo_err !== 1'b0 || uo_weights !== m_flat()) $display("FAIL ill_reload err %b want 0", uo_err); else n_pass++;
    cyc(1'b0, 1'b0, 16'h0);
    $display("test_illegal done");
  endtask

  task automatic test_async_reset();
    int done_seen = 0;
    for (int k = 0; k < 9; k++) cyc(1'b1, 1'b1, 16'($urandom));
    ena = 1'b1; ui_valid = 1'b1; ui_input = 16'hABCD;
    #2 rst = 1'b1;
    #1;
    model_reset();
    n_checks++;
    if (uo_weights !== '0 || uo_done !== 1'b0 || uo_wvalid !== 1'b0 || uo_err !== 1'b0 || uo_word_cnt !== 4'd0)
      $display("FAIL arst_outputs w %h d %b v %b e %b c %0d want all 0", uo_weights, uo_done, uo_wvalid, uo_err, uo_word_cnt);
    else n_pass++;
    @(posedge clk); #1;
    if (uo_done) done_seen++;
    rst = 1'b0;
    for (int k = 0; k < NW; k++) begin
      cyc(1'b1, 1'b1, 16'($urandom));
      if (k < NW - 1 && uo_done) done_seen++;
      if (k == 0) begin
        n_checks++; if (uo_word_cnt !== 4'd1) $display("FAIL arst_restart cnt %0d want 1", uo_word_cnt); else n_pass++;
      end
    end
    n_checks++; if (done_seen != 0) $display("FAIL arst_no_done got %0d want 0", done_seen); else n_pass++;
    n_checks++; if (uo_weights !== m_flat() || uo_done !== 1'b1) $display("FAIL arst_reload got %h want %h", uo_weights, m_flat()); else n_pass++;
    cyc(1'b0, 1'b0, 16'h0);
    $display("test_async_reset done");
  endtask

  task automatic test_back_to_back();
    logic [255:0] snap;
    logic [15:0]  w0;
    for (int k = 0; k < NW; k++) cyc(1'b1, 1'b1, 16'($urandom));
    snap = m_flat();
    cyc(1'b1, 1'b1, 16'hDEAD);
    n_checks++;
    if (uo_weights !== snap || uo_done !== 1'b0 || uo_word_cnt !== 4'd0 || uo_wvalid !== 1'b1)
      $display("FAIL b2b_done_ignores w %h d %b c %0d v %b", uo_weights, uo_done, uo_word_cnt, uo_wvalid);
    else n_pass++;
    w0 = 16'($urandom);
    cyc(1'b1, 1'b1, w0);
    n_checks++;
    if (uo_weights[15:0] !== san(w0) || uo_word_cnt !== 4'd1 || uo_wvalid !== 1'b0)
      $display("FAIL b2b_restart w0 %h cnt %0d v %b want %h 1 0", uo_weights[15:0], uo_word_cnt, uo_wvalid, san(w0));
    else n_pass++;
    cyc(1'b0, 1'b0, 16'h0);
    $display("test_back_to_back done");
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      cyc($urandom_range(0, 15) != 0, $urandom_range(0, 3) != 0, 16'($urandom));
      n_checks++;
      if ({uo_done, uo_wvalid, uo_err, uo_word_cnt} !== {m_done, m_wvalid, m_err, 4'(m_next)})
        $display("FAIL rand_ctrl i=%0d got d%b v%b e%b c%0d want d%b v%b e%b c%0d", i,
                 uo_done, uo_wvalid, uo_err, uo_word_cnt, m_done, m_wvalid, m_err, m_next);
      else n_pass++;
      n_checks++;
      if (uo_weights !== m_flat()) $display("FAIL rand_weights i=%0d got %h want %h", i, uo_weights, m_flat());
      else n_pass++;
    end
    $display("test_random done");
  endtask

  initial begin
    test_reset();
    test_full_load();
    test_valid_gaps();
    test_abort();
    test_illegal();
    test_async_reset();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
